// File: rtl/sz_ram_arb_if.sv
// Bundle of fitter, ANC and RAM-port signals around the S(z) coefficient RAM arbiter.
// The arbiter uses the slave view; the surrounding fitter/ANC/RAM environment uses master.
interface sz_ram_arb_if;
    logic               refit;
    logic               ofz_ok;
    logic               ofz_wren;
    logic        [6:0]  ofz_addr;
    logic signed [19:0] ofz_data;
    logic signed [19:0] ofz_sz;
    logic               ofz_rst_n;
    logic               anc_req;
    logic        [6:0]  anc_addr;
    logic signed [19:0] anc_sz;
    logic               anc_valid;
    logic               sz_ready;
    logic               wr_drop;
    logic               ram_wren;
    logic        [6:0]  ram_addr;
    logic        [19:0] ram_data;
    logic signed [19:0] ram_q;

    modport slave (
        input  refit, ofz_ok, ofz_wren, ofz_addr, ofz_data, anc_req, anc_addr, ram_q,
        output ofz_sz, ofz_rst_n, anc_sz, anc_valid, sz_ready, wr_drop,
        output ram_wren, ram_addr, ram_data
    );

    modport master (
        output refit, ofz_ok, ofz_wren, ofz_addr, ofz_data, anc_req, anc_addr, ram_q,
        input  ofz_sz, ofz_rst_n, anc_sz, anc_valid, sz_ready, wr_drop,
        input  ram_wren, ram_addr, ram_data
    );
endinterface

// File: rtl/sz_ram_arb.sv
// Owns the sz_ram port: clears it, lends it to the S(z) fitter, then serves ANC reads
// once the fitter has locked. Flags fitter writes that arrive outside the fit window.
module sz_ram_arb (
    input  logic         clk,
    input  logic         rst_n,
    sz_ram_arb_if.slave  bus
);
    typedef enum logic [1:0] {CLEAR, FIT, DRAIN, RUN} state_e;

    state_e     state_q, state_d;
    logic [6:0] clr_cnt_q, clr_cnt_d;
    logic       drn_cnt_q, drn_cnt_d;
    logic       ofz_rst_n_q, ofz_rst_n_d;
    logic       sz_ready_q, sz_ready_d;
    logic       anc_valid_q, anc_valid_d;
    logic       wr_drop_q, wr_drop_d;
    logic       refit_go;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        drn_cnt_d = drn_cnt_q;
        refit_go  = bus.refit && (state_q != CLEAR);

        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 7'd1;
                if (clr_cnt_q == 7'd127) state_d = FIT;
            end
            FIT: begin
                if (bus.ofz_ok) begin
                    state_d   = DRAIN;
                    drn_cnt_d = 1'b0;
                end
            end
            DRAIN: begin
                drn_cnt_d = 1'b1;
                if (drn_cnt_q) state_d = RUN;
            end
            default: ;
        endcase

        if (refit_go) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
        end

        // Status outputs reflect the state being entered, so they change on the same edge.
        ofz_rst_n_d = (state_d != CLEAR);
        sz_ready_d  = (state_d == RUN);
        anc_valid_d = (state_q == RUN) && bus.anc_req;
        wr_drop_d   = wr_drop_q | (bus.ofz_wren && (state_q == CLEAR || state_q == RUN));
        if (refit_go) wr_drop_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            drn_cnt_q   <= 1'b0;
            ofz_rst_n_q <= 1'b0;
            sz_ready_q  <= 1'b0;
            anc_valid_q <= 1'b0;
            wr_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            drn_cnt_q   <= drn_cnt_d;
            ofz_rst_n_q <= ofz_rst_n_d;
            sz_ready_q  <= sz_ready_d;
            anc_valid_q <= anc_valid_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    // RAM port mux; the clear write is gated by rst_n so nothing is written while held in reset.
    always_comb begin
        bus.ram_wren = 1'b0;
        bus.ram_addr = bus.anc_addr;
        bus.ram_data = '0;
        unique case (state_q)
            CLEAR: begin
                bus.ram_wren = rst_n;
                bus.ram_addr = clr_cnt_q;
            end
            FIT, DRAIN: begin
                bus.ram_wren = bus.ofz_wren;
                bus.ram_addr = bus.ofz_addr;
                bus.ram_data = bus.ofz_data;
            end
            default: ;
        endcase
    end

    assign bus.ofz_sz    = bus.ram_q;
    assign bus.anc_sz    = bus.ram_q;
    assign bus.ofz_rst_n = ofz_rst_n_q;
    assign bus.sz_ready  = sz_ready_q;
    assign bus.anc_valid = anc_valid_q;
    assign bus.wr_drop   = wr_drop_q;
endmodule

// File: tb/tb_sz_ram_arb.sv
// Bench for sz_ram_arb: behavioural 128x20 RAM, phase-level reference model,
// directed vector table, multi-cycle corner sequences and randomized traffic.
module tb_sz_ram_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sz_ram_arb_if bus();
    sz_ram_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    // sz_ram stand-in: registered read, read-before-write; filled with garbage while in reset.
    logic [19:0] ram [128];
    int fill_i = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            ram[fill_i[6:0]] <= 20'($urandom);
            fill_i <= fill_i + 1;
        end else if (bus.ram_wren) begin
            ram[bus.ram_addr] <= bus.ram_data;
        end
        bus.ram_q <= ram[bus.ram_addr];
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 clearing, 1 fitting, 2 draining, 3 running.
    int          ph, clr_idx, drn_left;
    logic [19:0] mem_m [128];
    logic        e_rstn, e_rdy, e_av, e_drop, q_chk;
    logic [19:0] e_q;

    task automatic model_reset();
        ph = 0; clr_idx = 0; drn_left = 0;
        e_rstn = 0; e_rdy = 0; e_av = 0; e_drop = 0; q_chk = 0; e_q = '0;
    endtask

    task automatic model_edge();
        int a;
        logic w;
        logic [19:0] wd;
        a = 0; w = 0; wd = '0; q_chk = 0;
        case (ph)
            0: begin a = clr_idx; w = 1; wd = '0; end
            1, 2: begin a = int'(bus.ofz_addr); w = bus.ofz_wren; wd = bus.ofz_data; q_chk = 1; end
            default: begin a = int'(bus.anc_addr); q_chk = bus.anc_req; end
        endcase
        e_q = mem_m[a];
        if (w) mem_m[a] = wd;
        e_av = (ph == 3) && bus.anc_req;
        if (bus.ofz_wren && (ph == 0 || ph == 3)) e_drop = 1;
        if (bus.refit && ph != 0) begin
            e_drop = 0; ph = 0; clr_idx = 0;
        end else begin
            case (ph)
                0: begin clr_idx++; if (clr_idx == 128) begin ph = 1; clr_idx = 0; end end
                1: if (bus.ofz_ok) begin ph = 2; drn_left = 2; end
                2: begin drn_left--; if (drn_left == 0) ph = 3; end
                default: ;
            endcase
        end
        e_rstn = (ph != 0);
        e_rdy  = (ph == 3);
    endtask

    task automatic check_out();
        chk("ofz_rst_n", bus.ofz_rst_n, e_rstn);
        chk("sz_ready", bus.sz_ready, e_rdy);
        chk("anc_valid", bus.anc_valid, e_av);
        chk("wr_drop", bus.wr_drop, e_drop);
        if (q_chk) begin
            if (e_av) chk("anc_sz", {12'b0, bus.anc_sz}, e_q);
            else      chk("ofz_sz", {12'b0, bus.ofz_sz}, e_q);
        end
    endtask

    // Inputs are set before calling; checks the RAM port, takes one edge, checks outputs.
    task automatic step();
        #1;
        if (ph == 0) begin
            chk("clr_wren", bus.ram_wren, 1);
            chk("clr_addr", bus.ram_addr, clr_idx);
            chk("clr_data", bus.ram_data, 0);
        end else if (ph == 3) begin
            chk("run_wren", bus.ram_wren, 0);
            chk("run_addr", bus.ram_addr, bus.anc_addr);
        end
        @(posedge clk);
        #1;
        model_edge();
        check_out();
    endtask

    task automatic idle_in();
        bus.refit = 0; bus.ofz_ok = 0; bus.ofz_wren = 0; bus.ofz_addr = '0;
        bus.ofz_data = '0; bus.anc_req = 0; bus.anc_addr = '0;
    endtask

    typedef struct {
        logic refit, ok, wren; logic [6:0] waddr; logic [19:0] wdata;
        logic areq; logic [6:0] aaddr;
        logic x_rstn, x_rdy, x_av, x_drop, chk_ofz; logic [19:0] x_sz;
    } vec_t;
    vec_t tbl [12];

    initial begin
        int rise;
        tbl[0]  = '{0,0,1,7'd5,20'h12345,1,7'd5, 1,0,0,0,0,20'h0};
        tbl[1]  = '{0,0,0,7'd5,20'h0,    0,7'd0, 1,0,0,0,1,20'h12345};
        tbl[2]  = '{0,1,0,7'd5,20'h0,    0,7'd0, 1,0,0,0,1,20'h12345};
        tbl[3]  = '{0,1,1,7'd6,20'h00777,0,7'd0, 1,0,0,0,0,20'h0};
        tbl[4]  = '{0,0,0,7'd0,20'h0,    1,7'd5, 1,1,0,0,0,20'h0};
        tbl[5]  = '{0,0,0,7'd0,20'h0,    1,7'd5, 1,1,1,0,0,20'h12345};
        tbl[6]  = '{0,0,0,7'd0,20'h0,    1,7'd6, 1,1,1,0,0,20'h00777};
        tbl[7]  = '{0,0,0,7'd0,20'h0,    0,7'd6, 1,1,0,0,0,20'h0};
        tbl[8]  = '{0,0,1,7'd5,20'h00001,0,7'd5, 1,1,0,1,0,20'h0};
        tbl[9]  = '{0,0,0,7'd0,20'h0,    1,7'd5, 1,1,1,1,0,20'h12345};
        tbl[10] = '{0,0,0,7'd0,20'h0,    0,7'd5, 1,1,0,1,0,20'h0};
        tbl[11] = '{1,0,0,7'd0,20'h0,    0,7'd5, 0,0,0,0,0,20'h0};

        for (int i = 0; i < 128; i++) mem_m[i] = '0;
        idle_in();
        model_reset();
        repeat (140) @(posedge clk);
        #1;
        chk("rst_ofz_rst_n", bus.ofz_rst_n, 0);
        chk("rst_sz_ready", bus.sz_ready, 0);
        chk("rst_anc_valid", bus.anc_valid, 0);
        chk("rst_wr_drop", bus.wr_drop, 0);
        chk("rst_ram_wren", bus.ram_wren, 0);
        rst_n = 1;

        // Initial clear: 128 zero writes, fitter released on the 128th edge.
        for (int i = 0; i < 128; i++) step();
        chk("fit_entry_rstn", bus.ofz_rst_n, 1);
        for (int i = 0; i < 128; i++) begin
            bus.ofz_addr = 7'(i);
            step();
        end

        // Directed fit / drain / run / refit table.
        for (int i = 0; i < 12; i++) begin
            bus.refit = tbl[i].refit; bus.ofz_ok = tbl[i].ok; bus.ofz_wren = tbl[i].wren;
            bus.ofz_addr = tbl[i].waddr; bus.ofz_data = tbl[i].wdata;
            bus.anc_req = tbl[i].areq; bus.anc_addr = tbl[i].aaddr;
            step();
            chk($sformatf("tbl%0d.rstn", i), bus.ofz_rst_n, tbl[i].x_rstn);
            chk($sformatf("tbl%0d.rdy", i), bus.sz_ready, tbl[i].x_rdy);
            chk($sformatf("tbl%0d.av", i), bus.anc_valid, tbl[i].x_av);
            chk($sformatf("tbl%0d.drop", i), bus.wr_drop, tbl[i].x_drop);
            if (tbl[i].x_av) chk($sformatf("tbl%0d.anc_sz", i), {12'b0, bus.anc_sz}, tbl[i].x_sz);
            if (tbl[i].chk_ofz) chk($sformatf("tbl%0d.ofz_sz", i), {12'b0, bus.ofz_sz}, tbl[i].x_sz);
        end
        idle_in();

        // Refit must have wiped the RAM.
        for (int i = 0; i < 128; i++) step();
        bus.ofz_addr = 7'd5; step();
        chk("refit_clr5", {12'b0, bus.ofz_sz}, 0);
        bus.ofz_addr = 7'd6; step();
        chk("refit_clr6", {12'b0, bus.ofz_sz}, 0);

        // refit and ofz_ok together: CLEAR wins.
        bus.refit = 1; bus.ofz_ok = 1; step();
        idle_in();
        chk("refit_ok_rstn", bus.ofz_rst_n, 0);
        chk("refit_ok_rdy", bus.sz_ready, 0);
        repeat (2) step();
        chk("refit_ok_still_clr", bus.ofz_rst_n, 0);

        // Reset mid-clear at clr_cnt=60.
        repeat (58) step();
        chk("mid_clr_addr", bus.ram_addr, 60);
        rst_n = 0;
        #1;
        chk("mid_rst_wren", bus.ram_wren, 0);
        chk("mid_rst_rstn", bus.ofz_rst_n, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        rise = -1;
        for (int i = 0; i < 200 && rise < 0; i++) begin
            step();
            if (bus.ofz_rst_n) rise = i + 1;
        end
        chk("mid_rst_clr_len", rise, 128);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.refit    = ($urandom_range(0, 199) == 0);
            bus.ofz_ok   = ($urandom_range(0, 29) == 0);
            bus.ofz_wren = ($urandom_range(0, 2) == 0);
            bus.ofz_addr = 7'($urandom_range(0, 15));
            bus.ofz_data = 20'($urandom);
            bus.anc_req  = $urandom_range(0, 1) == 1;
            bus.anc_addr = 7'($urandom_range(0, 15));
            step();
        end
        idle_in();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sz_ram_arb.md
# sz_ram_arb

Arbiter and sequencer for the secondary-path coefficient RAM (sz_ram, 128 × 20-bit, 1-cycle registered read). It sits between the offline S(z) fitter, which reads and writes coefficients during fitting, and the online ANC filter, which only reads them once fitting is done. It owns the RAM port and clears the RAM before each fit. It holds the fitter in reset while clearing, hands RAM ownership to the ANC side once the fitter self-locks, and flags any fitter write that arrives outside the fit window.

## Interface
- No parameters. RAM depth is 128 and data width is 20, both fixed by sz_ram.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- refit  in  1  single-cycle pulse that restarts the whole fit sequence.
- ofz_ok  in  1  fitter self-lock level; high means the fit is complete.
- ofz_wren  in  1  fitter write enable.
- ofz_addr  in  7  fitter read/write address.
- ofz_data  in  20 signed  fitter write data (sz_next).
- ofz_sz  out  20 signed  RAM read data returned to the fitter.
- ofz_rst_n  out  1  registered active-low reset driven to the fitter.
- anc_req  in  1  ANC read request.
- anc_addr  in  7  ANC read address.
- anc_sz  out  20 signed  ANC read data.
- anc_valid  out  1  anc_sz is valid this cycle.
- sz_ready  out  1  high in RUN; coefficients are stable.
- wr_drop  out  1  sticky flag: a fitter write was discarded.
- ram_wren  out  1  RAM write enable.
- ram_addr  out  7  RAM address.
- ram_data  out  20  RAM write data.
- ram_q  in  20 signed  RAM read data, available 1 cycle after ram_addr.

## Operation
- States: CLEAR, FIT, DRAIN, RUN.
- Reset entry: asynchronous reset places the FSM in CLEAR with clr_cnt=0.
- Reset values of outputs: ofz_rst_n=0, sz_ready=0, anc_valid=0, wr_drop=0, ram_wren=0.

**CLEAR**
- ram_wren=1, ram_addr=clr_cnt, ram_data=0.
- clr_cnt increments every cycle.
- After writing address 127, go to FIT.
- refit is ignored in this state.
- ofz_rst_n=0 for the whole state.

**FIT**
- The RAM port is driven combinationally by the fitter: ram_wren=ofz_wren, ram_addr=ofz_addr, ram_data=ofz_data.
- ofz_sz=ram_q.
- ofz_rst_n=1.
- anc_req is ignored: anc_valid stays 0.
- ofz_ok sampled high → DRAIN.

**DRAIN**
- Lasts 2 cycles, with a dedicated counter.
- Fitter writes in this state are still committed, so in-flight LMS updates complete.
- ANC requests are ignored.
- Exit to RUN.

**RUN**
- ram_wren=0, ram_addr=anc_addr.
- anc_valid is anc_req delayed by 1 cycle; anc_sz=ram_q.
- sz_ready=1.
- A fitter write (ofz_wren=1) sets wr_drop and is not forwarded to the RAM.
- ofz_sz=ram_q; the value is don't-care.

**refit**
- In FIT, DRAIN or RUN: the next state is CLEAR, clr_cnt=0, and wr_drop is cleared.
- ofz_rst_n drops on the next edge, which forces the fitter's ofz_ok low before FIT is re-entered.

**Priority and boundary rules**
- refit beats ofz_ok when both occur in the same cycle.
- ofz_ok is a level. It is acted on only in FIT; it is ignored in CLEAR and DRAIN.
- wr_drop is set in any non-FIT, non-DRAIN state. It stays set until refit or reset.
- In CLEAR, a fitter write is impossible because the fitter is held in reset; if one occurs anyway, it is dropped and wr_drop is set.
- ram_addr is don't-care in RUN when anc_req=0, but must be stable (hold anc_addr).
- clr_cnt is 7 bits wide. Its wrap from 127 to 0 coincides with the CLEAR→FIT transition.

## Timing
- CLEAR lasts exactly 128 cycles after reset deassertion, or after the refit edge plus 1.
- ofz_rst_n is registered: it goes high on the first FIT cycle and low on the first CLEAR cycle.
- Fitter read latency is 1 cycle; the mux is transparent, so the address-to-ofz_sz latency equals the RAM latency.
- Latency from ofz_ok high in FIT to sz_ready=1 is 3 edges: FIT→DRAIN, DRAIN(1)→DRAIN(2), DRAIN(2)→RUN.
- ANC read: anc_req/anc_addr at cycle n gives anc_valid=1 and anc_sz=RAM[anc_addr] at cycle n+1. Back-to-back requests give one result per cycle.
- A request issued on the last DRAIN cycle receives no response.

## Test plan
- Reset, then release: exactly 128 writes of 0 to addresses 0..127. Then FIT begins, with ofz_rst_n=1 on cycle 129 and all RAM reads returning 0.
- In FIT, write addr 5=0x12345, then read addr 5 → ofz_sz=0x12345 one cycle later. An anc_req in FIT gives anc_valid=0.
- Raise ofz_ok → sz_ready=1 exactly 3 cycles later. A fitter write during DRAIN lands in the RAM. ANC reads of addr 5 then stream 0x12345 with anc_valid lagging anc_req by 1 cycle.
- In RUN, pulse ofz_wren to addr 5 with 0x00001 → wr_drop=1 and RAM[5] stays 0x12345.
- Pulse refit in RUN → sz_ready=0, ofz_rst_n=0, and wr_drop cleared next cycle. All RAM reads return 0 after 128 cycles.
- Apply refit and ofz_ok together in FIT → CLEAR is entered, not DRAIN. Assert rst_n low mid-CLEAR (at clr_cnt=60) → clr_cnt restarts at 0 and 128 clear writes follow.
